// File: rtl/hazard_scheduler_if.sv
// D-stage operand/destination descriptors in, stall/bubble and MDU status out.
// The decoder side holds the master modport; the scheduler holds the slave.
interface hazard_scheduler_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_wa;
    logic [1:0] d_tnew;
    logic       d_md_use;
    logic       d_md_start;
    logic       d_md_div;
    logic       stall;
    logic       flush_e;
    logic       mdu_busy;
    logic [3:0] mdu_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
        output d_md_use, d_md_start, d_md_div,
        input  stall, flush_e, mdu_busy, mdu_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
        input  d_md_use, d_md_start, d_md_div,
        output stall, flush_e, mdu_busy, mdu_cnt
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Tnew/Tuse hazard detector with an E/M shadow scoreboard and a multi-cycle MDU
// busy counter; drives the PC/F-D freeze and the D/E bubble.
module hazard_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scheduler_if.slave hz
);
    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    logic [4:0] e_wa_q;
    logic [1:0] e_tnew_q;
    logic       e_md_start_q;
    logic       e_md_div_q;
    logic [4:0] m_wa_q;
    logic [1:0] m_tnew_q;
    logic [3:0] cnt_q;

    logic rs_haz;
    logic rt_haz;
    logic md_haz;
    logic busy;
    logic stall_int;

    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        // Register 0 and unread operands (tuse 3) never hazard.
        if (hz.d_rs != 5'd0 && hz.d_tuse_rs != 2'd3) begin
            rs_haz = (e_wa_q == hz.d_rs && e_tnew_q > hz.d_tuse_rs) ||
                     (m_wa_q == hz.d_rs && m_tnew_q > hz.d_tuse_rs);
        end
        if (hz.d_rt != 5'd0 && hz.d_tuse_rt != 2'd3) begin
            rt_haz = (e_wa_q == hz.d_rt && e_tnew_q > hz.d_tuse_rt) ||
                     (m_wa_q == hz.d_rt && m_tnew_q > hz.d_tuse_rt);
        end
        busy      = (cnt_q != 4'd0) || e_md_start_q;
        md_haz    = hz.d_md_use && busy;
        stall_int = rs_haz || rt_haz || md_haz;
    end

    assign hz.stall    = stall_int;
    assign hz.flush_e  = stall_int;
    assign hz.mdu_busy = busy;
    assign hz.mdu_cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_wa_q       <= 5'd0;
            e_tnew_q     <= 2'd0;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            m_wa_q       <= 5'd0;
            m_tnew_q     <= 2'd0;
            cnt_q        <= 4'd0;
        end else begin
            if (stall_int) begin
                e_wa_q       <= 5'd0;
                e_tnew_q     <= 2'd0;
                e_md_start_q <= 1'b0;
                e_md_div_q   <= 1'b0;
            end else begin
                e_wa_q       <= hz.d_wa;
                e_tnew_q     <= hz.d_tnew;
                e_md_start_q <= hz.d_md_start;
                e_md_div_q   <= hz.d_md_div;
            end
            m_wa_q   <= e_wa_q;
            m_tnew_q <= (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
            if (e_md_start_q) begin
                cnt_q <= e_md_div_q ? DivLoad : MultLoad;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench: instruction-level model (entry cycles, ages, MDU start time)
// checked every cycle, plus literal stall counts for the classic hazard cases.
module tb_hazard_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scheduler_if hz();

    hazard_scheduler #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every instruction that enters E is recorded with its entry cycle.
    typedef struct {
        int cyc;
        int wa;
        int tnew;
    } ent_t;

    ent_t q_ent[$];
    int   cyc = 0;
    int   md_start_cyc = -100;
    int   md_len = 0;

    function automatic int remaining(input int tnew, input int age);
        return (tnew - age > 0) ? tnew - age : 0;
    endfunction

    function automatic bit reg_haz(input int r, input int tuse);
        if (r == 0 || tuse == 3) return 1'b0;
        foreach (q_ent[i]) begin
            int age = cyc - q_ent[i].cyc;
            if (age >= 0 && age <= 1 && q_ent[i].wa == r && remaining(q_ent[i].tnew, age) > tuse)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        int age = cyc - md_start_cyc;
        return age >= 0 && age <= md_len;
    endfunction

    function automatic int m_cnt();
        int age = cyc - md_start_cyc;
        return (age >= 1 && age <= md_len) ? md_len - age + 1 : 0;
    endfunction

    function automatic bit m_stall();
        return reg_haz(int'(hz.d_rs), int'(hz.d_tuse_rs)) ||
               reg_haz(int'(hz.d_rt), int'(hz.d_tuse_rt)) ||
               (hz.d_md_use && m_busy());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ent.delete();
            cyc = 0;
            md_start_cyc = -100;
            md_len = 0;
        end else begin
            ent_t e;
            bit s = m_stall();
            e.cyc  = cyc + 1;
            e.wa   = s ? 0 : int'(hz.d_wa);
            e.tnew = s ? 0 : int'(hz.d_tnew);
            q_ent.push_back(e);
            if (q_ent.size() > 4) void'(q_ent.pop_front());
            if (!s && hz.d_md_start) begin
                md_start_cyc = cyc + 1;
                md_len = hz.d_md_div ? 10 : 5;
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", int'(hz.stall), int'(m_stall()));
            check("flush_e", int'(hz.flush_e), int'(m_stall()));
            check("mdu_busy", int'(hz.mdu_busy), int'(m_busy()));
            check("mdu_cnt", int'(hz.mdu_cnt), m_cnt());
        end
    end

    int cnt_log[40];

    // Called just after a rising edge; returns once the instruction enters E.
    task automatic issue(input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt,
                         input logic [4:0] wa, input logic [1:0] tnew,
                         input logic mu, input logic ms, input logic md,
                         output int stalls);
        bit done = 1'b0;
        bit st;
        #1;
        hz.d_rs = rs; hz.d_tuse_rs = trs; hz.d_rt = rt; hz.d_tuse_rt = trt;
        hz.d_wa = wa; hz.d_tnew = tnew;
        hz.d_md_use = mu; hz.d_md_start = ms; hz.d_md_div = md;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            st = hz.stall;
            cnt_log[i] = int'(hz.mdu_cnt);
            @(posedge clk);
            if (!st) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) check("issue_timeout", 0, 1);
    endtask

    task automatic nop(input int n);
        int s;
        for (int i = 0; i < n; i++) issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
    endtask

    int s;

    initial begin
        hz.d_rs = 5'd0; hz.d_tuse_rs = 2'd3; hz.d_rt = 5'd0; hz.d_tuse_rt = 2'd3;
        hz.d_wa = 5'd0; hz.d_tnew = 2'd0;
        hz.d_md_use = 1'b0; hz.d_md_start = 1'b0; hz.d_md_div = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", int'(hz.stall), 0);
        check("reset_cnt", int'(hz.mdu_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk);

        // lw $1; addu $2,$1,$3 (tuse 1) -> 1 stall
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, s);
        check("lw_addu_stalls", s, 1);
        nop(2);
        // lw $1; beq $1,$0 (tuse 0) -> 2 stalls
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        check("lw_beq_stalls", s, 2);
        nop(2);
        // lw $1; nop; beq $1 -> 1 stall
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, s);
        nop(1);
        issue(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        check("lw_gap_beq_stalls", s, 1);
        nop(2);
        // addu $1; beq $1 -> 1 stall; with wa = 0 -> none
        issue(5'd2, 2'd1, 5'd3, 2'd1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0, s);
        issue(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        check("alu_beq_stalls", s, 1);
        nop(2);
        issue(5'd2, 2'd1, 5'd3, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, s);
        issue(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s);
        check("wa0_beq_stalls", s, 0);
        nop(2);

        // mult; mflo -> 6 stalls, counter 0,5,4,3,2,1
        issue(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, s);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, s);
        check("mult_mflo_stalls", s, 6);
        check("mult_cnt_first", cnt_log[1], 5);
        check("mult_cnt_last", cnt_log[5], 1);
        check("mult_cnt_release", cnt_log[6], 0);
        nop(1);
        // div; mflo -> 11 stalls
        issue(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, s);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, s);
        check("div_mflo_stalls", s, 11);
        check("div_cnt_first", cnt_log[1], 10);
        nop(1);
        // mult; addu (no MDU use) passes; mflo then waits for cnt 5..1
        issue(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, s);
        issue(5'd7, 2'd1, 5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, s);
        check("busy_alu_stalls", s, 0);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b1, 1'b0, 1'b0, s);
        check("busy_mflo_stalls", s, 5);
        nop(2);

        // div, nops, lw $4, then addu $5,$4 stalled with cnt 7; reset mid-flight
        issue(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, s);
        nop(3);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0, s);
        #1;
        hz.d_rs = 5'd4; hz.d_tuse_rs = 2'd0; hz.d_rt = 5'd0; hz.d_tuse_rt = 2'd3;
        hz.d_wa = 5'd5; hz.d_tnew = 2'd1;
        hz.d_md_use = 1'b0; hz.d_md_start = 1'b0; hz.d_md_div = 1'b0;
        @(negedge clk);
        check("pre_rst_cnt", int'(hz.mdu_cnt), 7);
        check("pre_rst_stall", int'(hz.stall), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_stall", int'(hz.stall), 0);
        check("rst_flush", int'(hz.flush_e), 0);
        check("rst_busy", int'(hz.mdu_busy), 0);
        check("rst_cnt", int'(hz.mdu_cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stall", int'(hz.stall), 0);
        @(posedge clk);
        nop(2);

        // lw $7 (M) and lw $6 (E) feeding rt and rs of one consumer
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd6, 2'd0, 5'd7, 2'd0, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0, s);
        check("rs_rt_tuse0_stalls", s, 2);
        nop(2);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd2, 1'b0, 1'b0, 1'b0, s);
        issue(5'd6, 2'd1, 5'd7, 2'd0, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0, s);
        check("rs_rt_mixed_stalls", s, 1);
        nop(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard and multiply/divide scheduler for the five-stage core. It keeps a shadow scoreboard of the destination register and remaining result latency (Tnew) for the instructions in E and M. It compares that against the operand-use deadlines (Tuse) of the instruction in D. It also sequences the multi-cycle MDU busy window and produces the stall/bubble controls that freeze PC and F/D and clear the D/E pipeline register.

## Interface
Parameters:
- MULT_CYCLES, 5, MDU busy cycles for mult/multu
- DIV_CYCLES, 10, MDU busy cycles for div/divu

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- d_rs  in  5  rs field of instruction in D
- d_rt  in  5  rt field of instruction in D
- d_tuse_rs  in  2  cycles from D until rs value is consumed; 3 = rs not read
- d_tuse_rt  in  2  same for rt
- d_wa  in  5  destination register of D instruction; 0 = no write
- d_tnew  in  2  cycles after entering E until result is forwardable (ALU 1, load 2, none 0)
- d_md_use  in  1  D instruction touches HI/LO or MDU (mult/div/mfhi/mflo/mthi/mtlo)
- d_md_start  in  1  D instruction starts an MDU operation
- d_md_div  in  1  with d_md_start: 1 = divide, 0 = multiply
- stall  out  1  hold PC and F/D this cycle
- flush_e  out  1  load bubble into D/E at next edge
- mdu_busy  out  1  MDU operation in flight
- mdu_cnt  out  4  remaining MDU busy cycles (debug/verification)

## Operation
- Scoreboard entries: E = {wa, tnew, md_start, md_div}, M = {wa, tnew}.
- A bubble entry has wa = 0, tnew = 0, md_start = 0.
- Per clock, E advances:
  - if stall = 0: E <= {d_wa, d_tnew, d_md_start, d_md_div};
  - if stall = 1: E <= bubble.
- Per clock, M advances: M <= {E.wa, E.tnew == 0 ? 0 : E.tnew − 1}. M always advances; there is no M/W stall.
- Register hazard for rs, evaluated only when d_rs != 0 and d_tuse_rs != 3:
  - (E.wa == d_rs and E.tnew > d_tuse_rs), or
  - (M.wa == d_rs and M.tnew > d_tuse_rs).
- rt hazard is identical with d_rt and d_tuse_rt.
- Register 0 never causes a hazard. W-stage results are always forwardable and never stall.
- MDU counter (cnt):
  - loads MULT_CYCLES or DIV_CYCLES at the edge where E.md_start = 1, chosen by E.md_div;
  - otherwise decrements while nonzero; saturates at 0.
- mdu_busy = (cnt != 0) or E.md_start.
- MDU hazard = d_md_use and mdu_busy.
- stall = rs hazard or rt hazard or MDU hazard. flush_e = stall.
- Widths:
  - tnew and tuse compare as unsigned 2-bit values;
  - cnt is 4 bits, so DIV_CYCLES must be ≤ 15.

## Timing
- stall, flush_e and mdu_busy are combinational from D inputs and registered state, and are valid in the same cycle.
- The stalled instruction re-evaluates every cycle and is released in the first cycle all hazards clear.
- Load-use (tnew 2, tuse 0): exactly 2 stall cycles if the consumer immediately follows; 1 stall cycle if separated by one instruction.
- ALU-to-branch (tnew 1, tuse 0): 1 stall cycle when adjacent.
- MDU, for mult entering E at edge k:
  - cnt = 5 after edge k+1;
  - busy is high in the cycle after edge k through the cycle where cnt = 1;
  - a following mfhi in D stalls until then.
- Reset mid-operation: rst_n low asynchronously clears E, M and cnt. While held low: stall = 0, flush_e = 0, mdu_busy = 0, mdu_cnt = 0.
- Simultaneous d_md_start in D while busy: stalled like any d_md_use. A new MDU op never overlaps a running one.

## Test plan
- lw $1 then addu $2,$1,$3 (d_tuse_rs = 1, d_tnew of lw = 2): stall high exactly 1 cycle, then E holds addu; with tuse 0 (beq) stall high 2 cycles.
- addu $1 then beq $1,$0 (tnew 1, tuse 0): 1 stall cycle; same sequence with wa = 0: no stall.
- mult then mflo immediately: mflo stalls 6 cycles total (E.md_start cycle + 5); mdu_cnt reads 5,4,3,2,1,0; div variant gives 11 cycles.
- Non-MDU instruction (d_md_use = 0) while mdu_busy: no stall, E loads normally, cnt keeps decrementing.
- Assert rst_n low during div with cnt = 7 and a pending load-use stall: all outputs 0 immediately; after release, the same D instruction evaluated against an empty scoreboard does not stall.
- Back-to-back rs and rt hazards on different producers (E load to rs, M load to rt): stall persists until both clear; verify release cycle matches the larger remaining Tnew − Tuse.
